// File: rtl/argmax_seq_unit.sv
// argmax_seq_unit: sequential argmax over a NUM_CLASSES-entry score vector, lowest index wins ties.
// Latency: out_valid rises NUM_CLASSES-1 cycles after the accepting edge (one score per clock).
// Backpressure: result is held stable while out_ready=0; new vectors are refused until it retires.
// Optional: define ARGMAX_TOP2_EN to add runner-up index (second_idx) and margin outputs.
module argmax_seq_unit #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 29,
    parameter int SIGNED_CMP  = 1,
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] layer_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_W-1:0]                  predict,
    output logic [DATA_WIDTH-1:0]             max_value,
`ifdef ARGMAX_TOP2_EN
    output logic [IDX_W-1:0]                  second_idx,
    output logic [DATA_WIDTH:0]               margin,
`endif
    output logic                              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                            state;
    // Captured vector, shifted down one score per scan step so the
    // element under test always sits in the lowest DATA_WIDTH bits.
    logic [NUM_CLASSES*DATA_WIDTH-1:0] vec_q;
    logic [IDX_W-1:0]                  cnt;
    logic [DATA_WIDTH-1:0]             run_max;
    logic [IDX_W-1:0]                  run_idx;

    logic [DATA_WIDTH-1:0]             cur_dat;
    logic                              take_max;
    logic [DATA_WIDTH-1:0]             nxt_max;
    logic [IDX_W-1:0]                  nxt_idx;

`ifdef ARGMAX_TOP2_EN
    logic [DATA_WIDTH-1:0]             run2_val;
    logic [IDX_W-1:0]                  run2_idx;
    logic                              run2_vld;
    logic [DATA_WIDTH-1:0]             nxt2_val;
    logic [IDX_W-1:0]                  nxt2_idx;
    logic [DATA_WIDTH:0]               nxt_margin;
`endif

    // Strict greater-than under the configured signedness; equality never
    // wins, which is what keeps the lower index on ties.
    function automatic logic is_gt(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
        if (SIGNED_CMP != 0) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

`ifdef ARGMAX_TOP2_EN
    // One-bit extension so the max-minus-runner-up difference never overflows.
    function automatic logic [DATA_WIDTH:0] ext(input logic [DATA_WIDTH-1:0] v);
        return {(SIGNED_CMP != 0) && v[DATA_WIDTH-1], v};
    endfunction
`endif

    assign cur_dat = vec_q[DATA_WIDTH-1:0];

    // Running-max update for the element currently at the bottom of vec_q.
    always_comb begin
        take_max = is_gt(cur_dat, run_max);
        nxt_max  = run_max;
        nxt_idx  = run_idx;
        if (take_max) begin
            nxt_max = cur_dat;
            nxt_idx = cnt;
        end
    end

`ifdef ARGMAX_TOP2_EN
    // Runner-up update: a displaced maximum drops to second place, otherwise
    // the element fills an empty slot or beats the current runner-up.
    always_comb begin
        nxt2_val = run2_val;
        nxt2_idx = run2_idx;
        if (take_max) begin
            nxt2_val = run_max;
            nxt2_idx = run_idx;
        end else if (!run2_vld || is_gt(cur_dat, run2_val)) begin
            nxt2_val = cur_dat;
            nxt2_idx = cnt;
        end
        nxt_margin = ext(nxt_max) - ext(nxt2_val);
    end
`endif

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            predict    <= '0;
            max_value  <= '0;
            vec_q      <= '0;
            cnt        <= '0;
            run_max    <= '0;
            run_idx    <= '0;
`ifdef ARGMAX_TOP2_EN
            run2_val   <= '0;
            run2_idx   <= '0;
            run2_vld   <= 1'b0;
            second_idx <= '0;
            margin     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Element 0 seeds the running max; the rest is kept
                        // pre-shifted so element 1 is next in line.
                        vec_q    <= layer_out >> DATA_WIDTH;
                        run_max  <= layer_out[DATA_WIDTH-1:0];
                        run_idx  <= '0;
                        cnt      <= IDX_W'(1);
`ifdef ARGMAX_TOP2_EN
                        run2_vld <= 1'b0;
`endif
                        state    <= ST_SCAN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    run_max  <= nxt_max;
                    run_idx  <= nxt_idx;
                    vec_q    <= vec_q >> DATA_WIDTH;
                    cnt      <= cnt + 1'b1;
`ifdef ARGMAX_TOP2_EN
                    run2_val <= nxt2_val;
                    run2_idx <= nxt2_idx;
                    run2_vld <= 1'b1;
`endif
                    if (cnt == LAST_IDX) begin
                        // Last element processed: publish the final result.
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        predict    <= nxt_idx;
                        max_value  <= nxt_max;
`ifdef ARGMAX_TOP2_EN
                        second_idx <= nxt2_idx;
                        margin     <= nxt_margin;
`endif
                    end
                end
                ST_DONE: begin
                    // Retiring cycle never accepts: in_ready rises only after it.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_seq_unit.sv
// Bench for argmax_seq_unit: default signed instance, an unsigned twin fed the
// same stimulus, and a 2-class 8-bit instance. Expected results come from a
// plain whole-vector argmax model over the stored score array.
module tb_argmax_seq_unit;

    localparam int NC = 10;
    localparam int DW = 29;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // shared stimulus for signed (d_) and unsigned (u_) instances
    logic              in_valid;
    logic              out_ready;
    logic [NC*DW-1:0]  layer_out;
    logic              d_in_ready, d_out_valid, d_busy;
    logic [3:0]        d_predict;
    logic [DW-1:0]     d_max;
    logic              u_in_ready, u_out_valid, u_busy;
    logic [3:0]        u_predict;
    logic [DW-1:0]     u_max;
    // small instance
    logic              s_in_valid, s_out_ready;
    logic [15:0]       s_layer;
    logic              s_in_ready, s_out_valid, s_busy;
    logic [0:0]        s_predict;
    logic [7:0]        s_max;
`ifdef ARGMAX_TOP2_EN
    logic [3:0]        d_second, u_second;
    logic [DW:0]       d_margin, u_margin;
    logic [0:0]        s_second;
    logic [8:0]        s_margin;
`endif

    argmax_seq_unit #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .SIGNED_CMP(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
        .layer_out(layer_out), .out_valid(d_out_valid), .out_ready(out_ready),
        .predict(d_predict), .max_value(d_max),
`ifdef ARGMAX_TOP2_EN
        .second_idx(d_second), .margin(d_margin),
`endif
        .busy(d_busy));

    argmax_seq_unit #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .SIGNED_CMP(0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .layer_out(layer_out), .out_valid(u_out_valid), .out_ready(out_ready),
        .predict(u_predict), .max_value(u_max),
`ifdef ARGMAX_TOP2_EN
        .second_idx(u_second), .margin(u_margin),
`endif
        .busy(u_busy));

    argmax_seq_unit #(.NUM_CLASSES(2), .DATA_WIDTH(8), .SIGNED_CMP(1)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .layer_out(s_layer), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .predict(s_predict), .max_value(s_max),
`ifdef ARGMAX_TOP2_EN
        .second_idx(s_second), .margin(s_margin),
`endif
        .busy(s_busy));

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] sc [NC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // score as a plain integer under the chosen interpretation
    function automatic longint sval(input logic [DW-1:0] v, input bit sgn);
        if (sgn && v[DW-1]) return longint'(v) - (longint'(1) << DW);
        return longint'(v);
    endfunction

    function automatic int ref_best(input bit sgn);
        int best = 0;
        for (int k = 1; k < NC; k++)
            if (sval(sc[k], sgn) > sval(sc[best], sgn)) best = k;
        return best;
    endfunction

    // best among all classes other than the winner, lowest index on ties
    function automatic int ref_second(input bit sgn);
        int b = ref_best(sgn);
        int s = -1;
        for (int k = 0; k < NC; k++)
            if (k != b && (s < 0 || sval(sc[k], sgn) > sval(sc[s], sgn))) s = k;
        return s;
    endfunction

    function automatic logic [DW:0] ref_margin(input bit sgn);
        longint m = sval(sc[ref_best(sgn)], sgn) - sval(sc[ref_second(sgn)], sgn);
        return (DW+1)'(m);
    endfunction

    task automatic pack_scores();
        for (int k = 0; k < NC; k++) layer_out[k*DW +: DW] = sc[k];
    endtask

    task automatic scramble_input();
        for (int k = 0; k < NC; k++) layer_out[k*DW +: DW] = DW'($urandom);
    endtask

    // Send the vector in sc, check latency/result on both instances, optionally
    // stall the output for 'stall' cycles with a competing in_valid, then retire.
    task automatic run_vec(input string tag, input int stall);
        int lat;
        int unstable;
        int eb_s, eb_u;
        eb_s = ref_best(1);
        eb_u = ref_best(0);
        pack_scores();
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_input();
        chk({tag, ".busy"}, d_busy, 1);
        chk({tag, ".in_ready_low"}, d_in_ready, 0);
        lat = 0;
        while (!d_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, NC - 1);
        chk({tag, ".u_out_valid"}, u_out_valid, 1);
        chk({tag, ".predict_s"}, d_predict, eb_s);
        chk({tag, ".max_s"}, d_max, sc[eb_s]);
        chk({tag, ".predict_u"}, u_predict, eb_u);
        chk({tag, ".max_u"}, u_max, sc[eb_u]);
`ifdef ARGMAX_TOP2_EN
        chk({tag, ".second_s"}, d_second, ref_second(1));
        chk({tag, ".margin_s"}, d_margin, ref_margin(1));
        chk({tag, ".second_u"}, u_second, ref_second(0));
        chk({tag, ".margin_u"}, u_margin, ref_margin(0));
`endif
        if (stall > 0) begin
            in_valid = 1'b1;
            unstable = 0;
            repeat (stall) begin
                @(posedge clk); #1;
                if (d_predict !== 4'(eb_s) || d_max !== sc[eb_s] || d_in_ready !== 1'b0 ||
                    d_out_valid !== 1'b1 || u_predict !== 4'(eb_u) || u_max !== sc[eb_u])
                    unstable++;
            end
            chk({tag, ".stall_stable"}, unstable, 0);
            out_ready = 1'b1;
        end
        // retire edge; in_valid may still be high here and must not be taken
        @(posedge clk); #1;
        chk({tag, ".retired"}, d_out_valid, 0);
        chk({tag, ".in_ready_back"}, d_in_ready, 1);
        chk({tag, ".busy_low"}, d_busy, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        layer_out = '0;
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        s_layer = '0;
        #3;
        chk("rst.in_ready", d_in_ready, 1);
        chk("rst.out_valid", d_out_valid, 0);
        chk("rst.busy", d_busy, 0);
        chk("rst.predict", d_predict, 0);
        chk("rst.max", d_max, 0);
        chk("rst.small_in_ready", s_in_ready, 1);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // ascending scores k*100
        for (int k = 0; k < NC; k++) sc[k] = DW'(k * 100);
        run_vec("ramp", 0);

        // all negative except class 3 = 0
        for (int k = 0; k < NC; k++) sc[k] = DW'(29'h1000_0000 | DW'($urandom_range(0, 32'h0FFF_FFFF)));
        sc[3] = '0;
        run_vec("neg", 0);
        chk("neg.pred_const", d_predict, 3);
        chk("neg.max_const", d_max, 0);

        // tie between classes 2 and 7
        for (int k = 0; k < NC; k++) sc[k] = '0;
        sc[2] = 29'h0FFF_FFFF;
        sc[7] = 29'h0FFF_FFFF;
        run_vec("tie", 0);
        chk("tie.pred_const", d_predict, 2);
`ifdef ARGMAX_TOP2_EN
        chk("tie.second_const", d_second, 7);
        chk("tie.margin_const", d_margin, 0);
`endif

        // long output stall with competing input
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom);
        run_vec("stall", 20);

        // reset in the middle of a scan
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom);
        sc[4] = 29'h0000_0777;
        pack_scores();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort.out_valid", d_out_valid, 0);
        chk("abort.in_ready", d_in_ready, 1);
        chk("abort.busy", d_busy, 0);
        chk("abort.max_cleared", d_max, 0);
        #2 rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (d_out_valid || u_out_valid) seen++;
        end
        chk("abort.no_result", seen, 0);
        for (int k = 0; k < NC; k++) sc[k] = '0;
        sc[5] = 29'd1;
        run_vec("after_abort", 0);
        chk("after_abort.pred_const", d_predict, 5);

        // random vectors from a narrow signed range to force ties and sign mixes
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NC; k++) sc[k] = DW'($urandom_range(0, 6)) - DW'(3);
            run_vec($sformatf("rnd%0d", r), $urandom_range(0, 3));
        end

        // two-class 8-bit instance: {0x80, 0x7F}
        s_layer = {8'h7F, 8'h80};
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        chk("small.busy", s_busy, 1);
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("small.latency", lat, 1);
        chk("small.predict", s_predict, 1);
        chk("small.max", s_max, 8'h7F);
`ifdef ARGMAX_TOP2_EN
        chk("small.second", s_second, 0);
        chk("small.margin", s_margin, 9'd255);
`endif
        @(posedge clk); #1;
        chk("small.in_ready_back", s_in_ready, 1);
        chk("u.busy_idle", u_busy, 0);
        chk("u.in_ready_idle", u_in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
